// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath.
// Moore outputs from state and IR fields; BRANCH's PCWrite also follows zero/lt.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD,
    MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
    ALUWB, BRANCH, JAL, JALR1,
    JALR2, LUI
  } state_t;

  state_t state, next;
  logic [2:0] aluop;
  logic [2:0] immsel;
  logic       taken;
  logic       unused_f7;

  assign unused_f7 = ^{func7[6], func7[4:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  always_comb begin
    case (opcode)
      OP_LW, OP_I, OP_JALR: immsel = 3'b000;
      OP_SW:                immsel = 3'b001;
      OP_B:                 immsel = 3'b010;
      OP_JAL:               immsel = 3'b011;
      OP_LUI:               immsel = 3'b100;
      default:              immsel = 3'b000;
    endcase
  end

  // Only R-type uses func7[5] to turn add into sub.
  always_comb begin
    case (func3)
      3'b000:  aluop = (opcode == OP_R && func7[5])
                       ? 3'b001 : 3'b000;
      3'b111:  aluop = 3'b010;
      3'b110:  aluop = 3'b011;
      3'b010:  aluop = 3'b101;
      default: aluop = 3'b000;
    endcase
  end

  always_comb begin
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next       = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = immsel;
    RegWrite   = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECUTER;
          OP_I:         next = EXECUTEI;
          OP_B:         next = BRANCH;
          OP_JAL:       next = JAL;
          OP_JALR:      next = JALR1;
          OP_LUI:       next = LUI;
          default:      next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        next      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        next     = FETCH;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = aluop;
        next       = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = aluop;
        next       = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        next     = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = taken;
        next       = FETCH;
      end
      JAL, JALR2: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        next    = ALUWB;
      end
      JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = JALR2;
      end
      LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        next      = FETCH;
      end
      default: next = FETCH;
    endcase
    // Reset silences every output, FETCH's writes included.
    if (rst) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      ImmSrc     = 3'b000;
      RegWrite   = 1'b0;
    end
  end

endmodule
